// File: rtl/player_request_unit.sv
// player_request_unit: requester side of the req/gnt arbitration interface.
// Conditions an active-low push button (sync, debounce, press detect), runs the
// per-player round FSM against the arbiter's arm/grant/clear controls and keeps
// a saturating count of accepted presses.
module player_request_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_in_n,
    input  logic                   arm_in,
    input  logic                   gnt_in,
    input  logic                   clear_in,
    output logic                   req_out,
    output logic                   won_out,
    output logic                   false_start_out,
    output logic                   press_db_out,
    output logic [COUNT_WIDTH-1:0] press_count_out
);

    localparam int DCW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        REQ,
        GRANTED,
        FOUL
    } state_t;

    logic                   sync_ff1;
    logic                   sync_ff2;
    logic                   btn_s;
    logic                   btn_db;
    logic                   btn_db_d;
    logic [DCW-1:0]         db_cnt;
    logic                   press;
    logic [COUNT_WIDTH-1:0] press_count;
    state_t                 state;
    state_t                 state_next;

    // Two-flop synchronizer; both flops reset to the released (high) pin level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware it models.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= btn_in_n;
            sync_ff2 <= sync_ff1;
        end
    end

    assign btn_s = ~sync_ff2;

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= btn_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Registered rising-edge detect on the debounced level gives a one-cycle press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            press    <= btn_db & ~btn_db_d;
        end
    end

    // Saturating press counter; counts presses in every FSM state, including under clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= '0;
        end else if (press && (press_count != '1)) begin
            press_count <= press_count + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; clear_in dominates every other input.
    // NOTE: next-state takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (clear_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state_next = FOUL;
                    end else if (arm_in) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (press) begin
                        state_next = REQ;
                    end else if (!arm_in) begin
                        state_next = IDLE;
                    end
                end
                REQ: begin
                    if (gnt_in) begin
                        state_next = GRANTED;
                    end
                end
                GRANTED: state_next = GRANTED;
                FOUL:    state_next = FOUL;
                default: state_next = IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign req_out         = (state == REQ);
    assign won_out         = (state == GRANTED);
    assign false_start_out = (state == FOUL);
    assign press_db_out    = btn_db;
    assign press_count_out = press_count;

endmodule

// File: tb/tb_player_request_unit.sv
// tb_player_request_unit: scoreboard bench for player_request_unit.
// Expected press counts are queued when a qualifying press is driven and
// compared whenever the DUT's counter moves; FSM outputs are checked directly.
module tb_player_request_unit;

    localparam int DEB     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_in_n = 1'b1;
    logic          arm_in = 1'b0;
    logic          gnt_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          req_out;
    logic          won_out;
    logic          false_start_out;
    logic          press_db_out;
    logic [CW-1:0] press_count_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    int last_count = 0;
    int exp_q[$];

    player_request_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_in_n       (btn_in_n),
        .arm_in         (arm_in),
        .gnt_in         (gnt_in),
        .clear_in       (clear_in),
        .req_out        (req_out),
        .won_out        (won_out),
        .false_start_out(false_start_out),
        .press_db_out   (press_db_out),
        .press_count_out(press_count_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expected counter value for one accepted press (saturating).
    task automatic push_press();
        if (exp_cnt < CNT_MAX) begin
            exp_cnt++;
            exp_q.push_back(exp_cnt);
        end
    endtask

    // Hold the pin low for len sampled edges, then release long enough to settle.
    task automatic press_hold(input int len);
        if (len >= DEB) push_press();
        btn_in_n = 1'b0;
        tick(len);
        btn_in_n = 1'b1;
        tick(DEB + 8);
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
    endtask

    // Scoreboard consumer: every change of the counter must match the next queued value.
    always @(negedge clk) begin
        if (reset) begin
            last_count = 0;
        end else if (int'(press_count_out) != last_count) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", int'(press_count_out), last_count);
            end else begin
                check("sb_count", int'(press_count_out), exp_q.pop_front());
            end
            last_count = int'(press_count_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int rise_at;

        // Reset state
        tick(3);
        check("rst_req", req_out, 0);
        check("rst_won", won_out, 0);
        check("rst_fs", false_start_out, 0);
        check("rst_db", press_db_out, 0);
        check("rst_cnt", press_count_out, 0);
        reset = 1'b0;

        // 1: armed press, req_out rises 3+DEB edges after the pin is sampled low
        arm_in = 1'b1;
        tick(3);
        push_press();
        btn_in_n = 1'b0;
        k = cyc + 1;
        rise_at = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (req_out) begin
                rise_at = cyc;
                break;
            end
        end
        check("req_latency", rise_at - k, DEB + 3);
        check("db_held", press_db_out, 1);
        check("t1_cnt", press_count_out, 1);
        tick(13);
        btn_in_n = 1'b1;
        tick(DEB + 8);
        check("req_held", req_out, 1);

        // 2: grant pulse then clear
        gnt_in = 1'b1;
        tick(1);
        gnt_in = 1'b0;
        check("gnt_won", won_out, 1);
        check("gnt_req", req_out, 0);
        tick(4);
        check("won_held", won_out, 1);
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        arm_in = 1'b0;
        check("clr_won", won_out, 0);
        check("clr_req", req_out, 0);
        check("clr_fs", false_start_out, 0);
        tick(2);

        // 3: false start, arm does not rescue it, clear returns to IDLE
        push_press();
        btn_in_n = 1'b0;
        tick(DEB + 3);
        check("fs_early", false_start_out, 0);
        tick(1);
        check("fs_set", false_start_out, 1);
        arm_in = 1'b1;
        tick(5);
        check("fs_armed", false_start_out, 1);
        check("fs_req", req_out, 0);
        tick(7);
        btn_in_n = 1'b1;
        tick(DEB + 8);
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        arm_in = 1'b0;
        check("fs_clr", false_start_out, 0);
        tick(2);

        // 4: glitches shorter than DEB give nothing; DEB cycles gives one event
        for (int len = 1; len < DEB; len++) begin
            press_hold(len);
            check("glitch_cnt", press_count_out, 2);
            check("glitch_fs", false_start_out, 0);
        end
        press_hold(DEB);
        check("edge_cnt", press_count_out, 3);
        check("edge_fs", false_start_out, 1);
        pulse_clear();

        // 5: press and clear on the same edge in ARMED
        arm_in = 1'b1;
        tick(2);
        push_press();
        btn_in_n = 1'b0;
        tick(DEB + 3);
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        check("pc_req", req_out, 0);
        check("pc_won", won_out, 0);
        check("pc_fs", false_start_out, 0);
        check("pc_cnt", press_count_out, 4);
        tick(12);
        btn_in_n = 1'b1;
        tick(DEB + 8);
        check("pc_no_req", req_out, 0);
        arm_in = 1'b0;

        // 6: saturation, then reset in the middle of REQ
        check("sb_drained", exp_q.size(), 0);
        reset = 1'b1;
        tick(2);
        check("rst2_cnt", press_count_out, 0);
        reset = 1'b0;
        exp_cnt = 0;
        tick(2);
        for (int i = 1; i <= 17; i++) begin
            press_hold(DEB + 2);
            check("sat_cnt", press_count_out, (i < CNT_MAX) ? i : CNT_MAX);
        end
        pulse_clear();
        arm_in = 1'b1;
        tick(2);
        btn_in_n = 1'b0;
        tick(DEB + 4);
        check("pre_rst_req", req_out, 1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_req", req_out, 0);
        check("mid_rst_won", won_out, 0);
        check("mid_rst_fs", false_start_out, 0);
        check("mid_rst_db", press_db_out, 0);
        check("mid_rst_cnt", press_count_out, 0);
        btn_in_n = 1'b1;
        arm_in = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);

        check("sb_final", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
